// File: rtl/scan_select_sequencer.sv
// Address/enable sequencer for the 4-to-16 decoder: dwell on each channel, optional blanking gap, 1-cycle start latency.
// No backpressure: free-running once started; stop aborts to IDLE on the next cycle.
module scan_select_sequencer #(
    parameter int DWELL = 4,
    parameter int BLANK = 1,
    parameter int LAST  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       single,
    input  logic [3:0] start_addr,
    output logic [3:0] w,
    output logic       e,
    output logic       busy,
    output logic       wrap,
    output logic       done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] BLANKS = 2'd2;

    localparam logic [3:0]  LAST_W   = 4'(LAST);
    localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);
    localparam logic [15:0] BLANK_M1 = 16'(BLANK - 1);
    localparam logic        HAS_GAP  = (BLANK > 0);

    logic [1:0]  state;
    logic [15:0] dwell_cnt;
    logic [15:0] blank_cnt;
    logic        mode;
    logic [3:0]  next_w;
    logic        at_last;

    always_comb begin
        at_last = (w == LAST_W);
        next_w  = at_last ? 4'd0 : w + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            w         <= 4'd0;
            e         <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= 16'd0;
            blank_cnt <= 16'd0;
            mode      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    e    <= 1'b0;
                    busy <= 1'b0;
                    if (start && !stop && (start_addr <= LAST_W)) begin
                        state     <= ACTIVE;
                        w         <= start_addr;
                        e         <= 1'b1;
                        busy      <= 1'b1;
                        mode      <= single;
                        dwell_cnt <= 16'd0;
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        state     <= IDLE;
                        e         <= 1'b0;
                        busy      <= 1'b0;
                        dwell_cnt <= 16'd0;
                    end else if (dwell_cnt == DWELL_M1) begin
                        dwell_cnt <= 16'd0;
                        if (mode && at_last) begin
                            // single pass ends here; the trailing gap is skipped
                            state <= IDLE;
                            e     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (HAS_GAP) begin
                            state     <= BLANKS;
                            e         <= 1'b0;
                            blank_cnt <= 16'd0;
                        end else begin
                            w    <= next_w;
                            wrap <= at_last && !mode;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 16'd1;
                    end
                end
                BLANKS: begin
                    if (stop) begin
                        state     <= IDLE;
                        e         <= 1'b0;
                        busy      <= 1'b0;
                        blank_cnt <= 16'd0;
                    end else if (blank_cnt == BLANK_M1) begin
                        state     <= ACTIVE;
                        w         <= next_w;
                        e         <= 1'b1;
                        wrap      <= at_last && !mode;
                        blank_cnt <= 16'd0;
                        dwell_cnt <= 16'd0;
                    end else begin
                        blank_cnt <= blank_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    e         <= 1'b0;
                    busy      <= 1'b0;
                    dwell_cnt <= 16'd0;
                    blank_cnt <= 16'd0;
                end
            endcase
        end
    end

endmodule
